// File: rtl/cpu_mem_stage_if.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : cpu_mem_stage_if                                              |
// | Purpose  : Data-bus handshake between the memory stage (master) and the  |
// |            data memory / bus fabric (slave).                             |
// | Signals  : d_req   - bus request                                         |
// |            d_we    - write strobe (store)                                |
// |            d_addr  - byte address                                        |
// |            d_wdata - store data                                          |
// |            d_rdata - load data returned by the slave                     |
// |            d_rdy   - slave ready; completes the access when d_req is high|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_mem_stage_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_rdy;

  modport master (
    output d_req,
    output d_we,
    output d_addr,
    output d_wdata,
    input  d_rdata,
    input  d_rdy
  );

  modport slave (
    input  d_req,
    input  d_we,
    input  d_addr,
    input  d_wdata,
    output d_rdata,
    output d_rdy
  );
endinterface

`default_nettype wire

// File: rtl/cpu_mem_stage.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : cpu_mem_stage                                                 |
// | Purpose  : PLP CPU memory-access stage. Issues loads/stores on the data  |
// |            bus, stalls the front of the pipe while the bus inserts wait  |
// |            states, aborts accesses that exceed MAX_WAIT wait cycles and  |
// |            registers the result bundle for write-back.                   |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            ex_*            - execute-stage pipeline register outputs     |
// |            bus (master)    - data-bus handshake (cpu_mem_stage_if)       |
// |            stall           - freeze upstream pipeline registers          |
// |            p_*             - registered write-back bundle                |
// |            p_bus_err       - one-cycle pulse on an aborted access        |
// |            misalign_addr   - address of last misaligned access           |
// |                              (only with CPU_MEM_ALIGN_CHECK_EN)          |
// | Options  : CPU_MEM_ALIGN_CHECK_EN - reject word-misaligned accesses      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module cpu_mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        ex_c_rfw,
  input  wire logic [1:0]  ex_c_wbsource,
  input  wire logic        ex_c_drw,
  input  wire logic [31:0] ex_alu_r,
  input  wire logic [31:0] ex_rfb,
  input  wire logic [4:0]  ex_rf_waddr,
  input  wire logic [31:0] ex_jalra,
  cpu_mem_stage_if.master  bus,
  output logic             stall,
  output logic             p_c_rfw,
  output logic [1:0]       p_c_wbsource,
  output logic [31:0]      p_alu_r,
  output logic [31:0]      p_mem_rdata,
  output logic [31:0]      p_jalra,
  output logic [4:0]       p_rf_waddr,
  output logic             p_bus_err
`ifdef CPU_MEM_ALIGN_CHECK_EN
  ,
  output logic [31:0]      misalign_addr
`endif
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [1:0] WB_MEM     = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        p_c_rfw_q, p_c_rfw_d;
  logic [1:0]  p_c_wbsource_q, p_c_wbsource_d;
  logic [31:0] p_alu_r_q, p_alu_r_d;
  logic [31:0] p_mem_rdata_q, p_mem_rdata_d;
  logic [31:0] p_jalra_q, p_jalra_d;
  logic [4:0]  p_rf_waddr_q, p_rf_waddr_d;
  logic        p_bus_err_q, p_bus_err_d;

  logic        mem_access;
  logic        misaligned;
  logic        bus_access;
  logic        req;
  logic        done;

  // Access classification and bus handshake
  always_comb begin
    mem_access = ex_c_drw | (ex_c_wbsource == WB_MEM);
`ifdef CPU_MEM_ALIGN_CHECK_EN
    misaligned = mem_access & (ex_alu_r[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    bus_access = mem_access & ~misaligned;
    // Reset drops the request in the same cycle, before the flops clear.
    req        = ~rst & bus_access & (state_q != S_ABORT);
    done       = req & bus.d_rdy;
    stall      = req & ~bus.d_rdy;
  end

  assign bus.d_req   = req;
  assign bus.d_we    = ex_c_drw;
  assign bus.d_addr  = ex_alu_r;
  assign bus.d_wdata = ex_rfb;

  // FSM next state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (stall) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        // Ready on the final permitted cycle still completes the access.
        if (done) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == MAX_WAIT_C) begin
          state_d = S_ABORT;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Write-back pipeline register next values
  always_comb begin
    p_c_rfw_d      = p_c_rfw_q;
    p_c_wbsource_d = p_c_wbsource_q;
    p_alu_r_d      = p_alu_r_q;
    p_mem_rdata_d  = p_mem_rdata_q;
    p_jalra_d      = p_jalra_q;
    p_rf_waddr_d   = p_rf_waddr_q;
    p_bus_err_d    = p_bus_err_q;
    if (stall) begin
      // Bubble: write-back sees a no-op while data fields keep their values.
      p_c_rfw_d      = 1'b0;
      p_c_wbsource_d = 2'd0;
      p_bus_err_d    = 1'b0;
    end else if (state_q == S_ABORT) begin
      p_c_rfw_d      = 1'b0;
      p_c_wbsource_d = ex_c_wbsource;
      p_alu_r_d      = ex_alu_r;
      p_mem_rdata_d  = 32'd0;
      p_jalra_d      = ex_jalra;
      p_rf_waddr_d   = ex_rf_waddr;
      p_bus_err_d    = 1'b1;
    end else begin
      p_c_rfw_d      = ex_c_rfw & ~misaligned;
      p_c_wbsource_d = ex_c_wbsource;
      p_alu_r_d      = ex_alu_r;
      p_mem_rdata_d  = done ? bus.d_rdata : 32'd0;
      p_jalra_d      = ex_jalra;
      p_rf_waddr_d   = ex_rf_waddr;
      p_bus_err_d    = misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      p_c_rfw_q      <= 1'b0;
      p_c_wbsource_q <= 2'd0;
      p_alu_r_q      <= 32'd0;
      p_mem_rdata_q  <= 32'd0;
      p_jalra_q      <= 32'd0;
      p_rf_waddr_q   <= 5'd0;
      p_bus_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      p_c_rfw_q      <= p_c_rfw_d;
      p_c_wbsource_q <= p_c_wbsource_d;
      p_alu_r_q      <= p_alu_r_d;
      p_mem_rdata_q  <= p_mem_rdata_d;
      p_jalra_q      <= p_jalra_d;
      p_rf_waddr_q   <= p_rf_waddr_d;
      p_bus_err_q    <= p_bus_err_d;
    end
  end

`ifdef CPU_MEM_ALIGN_CHECK_EN
  logic [31:0] misalign_addr_q, misalign_addr_d;

  always_comb begin
    misalign_addr_d = misalign_addr_q;
    if (misaligned) begin
      misalign_addr_d = ex_alu_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_addr_q <= 32'd0;
    end else begin
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_addr = misalign_addr_q;
`endif

  assign p_c_rfw      = p_c_rfw_q;
  assign p_c_wbsource = p_c_wbsource_q;
  assign p_alu_r      = p_alu_r_q;
  assign p_mem_rdata  = p_mem_rdata_q;
  assign p_jalra      = p_jalra_q;
  assign p_rf_waddr   = p_rf_waddr_q;
  assign p_bus_err    = p_bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_stage.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu_mem_stage                                              |
// | Purpose  : Self-checking bench for cpu_mem_stage (MAX_WAIT = 4).         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_mem_stage;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_c_rfw;
  logic [1:0]  ex_c_wbsource;
  logic        ex_c_drw;
  logic [31:0] ex_alu_r;
  logic [31:0] ex_rfb;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_jalra;
  logic        stall;
  logic        p_c_rfw;
  logic [1:0]  p_c_wbsource;
  logic [31:0] p_alu_r;
  logic [31:0] p_mem_rdata;
  logic [31:0] p_jalra;
  logic [4:0]  p_rf_waddr;
  logic        p_bus_err;
`ifdef CPU_MEM_ALIGN_CHECK_EN
  logic [31:0] misalign_addr;
`endif

  cpu_mem_stage_if bus ();

  always #5 clk = ~clk;

  cpu_mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_c_rfw      (ex_c_rfw),
    .ex_c_wbsource (ex_c_wbsource),
    .ex_c_drw      (ex_c_drw),
    .ex_alu_r      (ex_alu_r),
    .ex_rfb        (ex_rfb),
    .ex_rf_waddr   (ex_rf_waddr),
    .ex_jalra      (ex_jalra),
    .bus           (bus),
    .stall         (stall),
    .p_c_rfw       (p_c_rfw),
    .p_c_wbsource  (p_c_wbsource),
    .p_alu_r       (p_alu_r),
    .p_mem_rdata   (p_mem_rdata),
    .p_jalra       (p_jalra),
    .p_rf_waddr    (p_rf_waddr),
    .p_bus_err     (p_bus_err)
`ifdef CPU_MEM_ALIGN_CHECK_EN
    ,
    .misalign_addr (misalign_addr)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rfw;
    logic [1:0]  wb;
    logic        drw;
    logic [31:0] alu;
    logic [31:0] rfb;
    logic [4:0]  waddr;
    logic [31:0] jalra;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic        e_rfw;
    logic [31:0] e_mdata;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rfw, input logic [1:0] wb, input logic drw,
                       input logic [31:0] alu, input logic [31:0] rfb,
                       input logic [4:0] waddr, input logic [31:0] jalra);
    ex_c_rfw      = rfw;
    ex_c_wbsource = wb;
    ex_c_drw      = drw;
    ex_alu_r      = alu;
    ex_rfb        = rfb;
    ex_rf_waddr   = waddr;
    ex_jalra      = jalra;
  endtask

  task automatic nop;
    drive(1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int writes;
    logic [31:0] prev_alu;

    // Single-cycle instructions: non-access and zero-wait accesses.
    //          rfw  wb    drw   alu            rfb            wa     jalra          rdy   rdata          req   we    e_rfw mdata
    vecs[0] = '{1'b1, 2'd0, 1'b0, 32'h0000_1234, 32'h0000_0000, 5'd5,  32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[1] = '{1'b1, 2'd1, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'd7,  32'h0000_0044, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 32'h0000_0204, 32'h1122_3344, 5'd0,  32'h0000_0048, 1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 32'h0000_0055};
    vecs[3] = '{1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd31, 32'h8000_0010, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{1'b1, 2'd1, 1'b1, 32'h0000_0308, 32'h0BAD_F00D, 5'd12, 32'h0000_0050, 1'b1, 32'h0000_0077, 1'b1, 1'b1, 1'b1, 32'h0000_0077};

    // Reset with a load presented: no request may leave the stage.
    rst = 1'b1;
    bus.d_rdy   = 1'b0;
    bus.d_rdata = 32'h0;
    drive(1'b1, 2'd1, 1'b0, 32'h0000_0100, 32'h0, 5'd1, 32'h0);
    #2;
    chk("rst_d_req", {31'd0, bus.d_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    tick;
    tick;
    chk("rst_p_c_rfw", {31'd0, p_c_rfw}, 32'd0);
    chk("rst_p_wbsource", {30'd0, p_c_wbsource}, 32'd0);
    chk("rst_p_alu_r", p_alu_r, 32'd0);
    chk("rst_p_mem_rdata", p_mem_rdata, 32'd0);
    chk("rst_p_jalra", p_jalra, 32'd0);
    chk("rst_p_rf_waddr", {27'd0, p_rf_waddr}, 32'd0);
    chk("rst_p_bus_err", {31'd0, p_bus_err}, 32'd0);
`ifdef CPU_MEM_ALIGN_CHECK_EN
    chk("rst_misalign_addr", misalign_addr, 32'd0);
`endif
    rst = 1'b0;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].rfw, vecs[i].wb, vecs[i].drw, vecs[i].alu, vecs[i].rfb,
            vecs[i].waddr, vecs[i].jalra);
      bus.d_rdy   = vecs[i].rdy;
      bus.d_rdata = vecs[i].rdata;
      #2;
      chk($sformatf("v%0d_d_req", i), {31'd0, bus.d_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_d_we", i), {31'd0, bus.d_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_d_addr", i), bus.d_addr, vecs[i].alu);
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      tick;
      chk($sformatf("v%0d_p_c_rfw", i), {31'd0, p_c_rfw}, {31'd0, vecs[i].e_rfw});
      chk($sformatf("v%0d_p_wbsource", i), {30'd0, p_c_wbsource}, {30'd0, vecs[i].wb});
      chk($sformatf("v%0d_p_alu_r", i), p_alu_r, vecs[i].alu);
      chk($sformatf("v%0d_p_mem_rdata", i), p_mem_rdata, vecs[i].e_mdata);
      chk($sformatf("v%0d_p_jalra", i), p_jalra, vecs[i].jalra);
      chk($sformatf("v%0d_p_rf_waddr", i), {27'd0, p_rf_waddr}, {27'd0, vecs[i].waddr});
      chk($sformatf("v%0d_p_bus_err", i), {31'd0, p_bus_err}, 32'd0);
    end
    prev_alu = 32'h0000_0308;

    // Store with three wait states: stall for 3 cycles, bubbles downstream.
    writes = 0;
    drive(1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 32'h0000_0060);
    bus.d_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (bus.d_req && bus.d_rdy && bus.d_we) writes++;
      chk($sformatf("st_w%0d_stall", i), {31'd0, stall}, 32'd1);
      chk($sformatf("st_w%0d_d_we", i), {31'd0, bus.d_we}, 32'd1);
      chk($sformatf("st_w%0d_d_addr", i), bus.d_addr, 32'h0000_0200);
      chk($sformatf("st_w%0d_d_wdata", i), bus.d_wdata, 32'hA5A5_A5A5);
      tick;
      chk($sformatf("st_w%0d_bubble_rfw", i), {31'd0, p_c_rfw}, 32'd0);
      chk($sformatf("st_w%0d_bubble_wb", i), {30'd0, p_c_wbsource}, 32'd0);
      chk($sformatf("st_w%0d_hold_alu", i), p_alu_r, prev_alu);
    end
    bus.d_rdy   = 1'b1;
    bus.d_rdata = 32'h0;
    #2;
    if (bus.d_req && bus.d_rdy && bus.d_we) writes++;
    chk("st_done_stall", {31'd0, stall}, 32'd0);
    chk("st_done_d_req", {31'd0, bus.d_req}, 32'd1);
    tick;
    chk("st_writes", writes, 32'd1);
    chk("st_p_alu_r", p_alu_r, 32'h0000_0200);
    chk("st_p_bus_err", {31'd0, p_bus_err}, 32'd0);

    // Load that never gets ready: IDLE + 4 WAIT stall cycles, then ABORT.
    drive(1'b1, 2'd1, 1'b0, 32'h0000_0300, 32'h0, 5'd9, 32'h0000_0070);
    bus.d_rdy   = 1'b0;
    bus.d_rdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("ab_c%0d_stall", i), {31'd0, stall}, 32'd1);
      tick;
      chk($sformatf("ab_c%0d_bus_err", i), {31'd0, p_bus_err}, 32'd0);
    end
    #2;
    chk("ab_abort_d_req", {31'd0, bus.d_req}, 32'd0);
    chk("ab_abort_stall", {31'd0, stall}, 32'd0);
    tick;
    chk("ab_p_bus_err", {31'd0, p_bus_err}, 32'd1);
    chk("ab_p_c_rfw", {31'd0, p_c_rfw}, 32'd0);
    chk("ab_p_mem_rdata", p_mem_rdata, 32'd0);
    chk("ab_p_wbsource", {30'd0, p_c_wbsource}, 32'd1);
    chk("ab_p_alu_r", p_alu_r, 32'h0000_0300);
    chk("ab_p_rf_waddr", {27'd0, p_rf_waddr}, 32'd9);
    // FSM back in IDLE: a zero-wait load completes straight away.
    drive(1'b1, 2'd1, 1'b0, 32'h0000_0310, 32'h0, 5'd10, 32'h0);
    bus.d_rdy   = 1'b1;
    bus.d_rdata = 32'h2468_ACE0;
    #2;
    chk("ab_next_d_req", {31'd0, bus.d_req}, 32'd1);
    chk("ab_next_stall", {31'd0, stall}, 32'd0);
    tick;
    chk("ab_next_bus_err", {31'd0, p_bus_err}, 32'd0);
    chk("ab_next_mdata", p_mem_rdata, 32'h2468_ACE0);

    // Ready arriving exactly when the counter hits MAX_WAIT completes normally.
    drive(1'b1, 2'd1, 1'b0, 32'h0000_0320, 32'h0, 5'd11, 32'h0);
    bus.d_rdy = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    bus.d_rdy   = 1'b1;
    bus.d_rdata = 32'hBEEF_0001;
    #2;
    chk("lim_stall", {31'd0, stall}, 32'd0);
    chk("lim_d_req", {31'd0, bus.d_req}, 32'd1);
    tick;
    chk("lim_p_mem_rdata", p_mem_rdata, 32'hBEEF_0001);
    chk("lim_p_bus_err", {31'd0, p_bus_err}, 32'd0);
    chk("lim_p_c_rfw", {31'd0, p_c_rfw}, 32'd1);

    // Reset during the second WAIT cycle.
    drive(1'b1, 2'd1, 1'b0, 32'h0000_0330, 32'h0, 5'd13, 32'h0000_0090);
    bus.d_rdy = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #2;
    chk("rw_d_req", {31'd0, bus.d_req}, 32'd0);
    tick;
    chk("rw_p_c_rfw", {31'd0, p_c_rfw}, 32'd0);
    chk("rw_p_alu_r", p_alu_r, 32'd0);
    chk("rw_p_jalra", p_jalra, 32'd0);
    chk("rw_p_rf_waddr", {27'd0, p_rf_waddr}, 32'd0);
    chk("rw_p_mem_rdata", p_mem_rdata, 32'd0);
    rst = 1'b0;
    drive(1'b1, 2'd1, 1'b0, 32'h0000_0400, 32'h0, 5'd14, 32'h0);
    bus.d_rdy   = 1'b1;
    bus.d_rdata = 32'h1234_5678;
    #2;
    chk("rw_fresh_d_req", {31'd0, bus.d_req}, 32'd1);
    chk("rw_fresh_stall", {31'd0, stall}, 32'd0);
    tick;
    chk("rw_fresh_mdata", p_mem_rdata, 32'h1234_5678);
    chk("rw_fresh_rfw", {31'd0, p_c_rfw}, 32'd1);

`ifdef CPU_MEM_ALIGN_CHECK_EN
    // Misaligned load never reaches the bus.
    drive(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 5'd3, 32'h0);
    bus.d_rdy   = 1'b1;
    bus.d_rdata = 32'h9999_9999;
    #2;
    chk("mis_d_req", {31'd0, bus.d_req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick;
    chk("mis_p_bus_err", {31'd0, p_bus_err}, 32'd1);
    chk("mis_p_c_rfw", {31'd0, p_c_rfw}, 32'd0);
    chk("mis_addr", misalign_addr, 32'h0000_0102);
    chk("mis_p_mem_rdata", p_mem_rdata, 32'd0);
    nop;
    tick;
    chk("mis_err_pulse_end", {31'd0, p_bus_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
